// File: rtl/rand_note_sched.sv
// rand_note_sched: schedules a sequence of SEQ_LEN random notes.
// Each note is drawn from external LFSRs, offered to a tone player with a
// valid/ready handshake, and then gated for 1..4 tempo beats.
// Optional feature macro: RAND_NOTE_SCHED_REST_EN (adds note_rest; pitch 15 becomes a rest).
module rand_note_sched #(
  parameter int unsigned SEQ_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       beat_tick,
  input  logic [3:0] rand_note,
  input  logic [1:0] rand_length,
  output logic       enable_rand,
  output logic       note_valid,
  input  logic       note_ready,
  output logic [3:0] note_idx,
  output logic       note_on,
  output logic       busy,
  output logic       done,
  output logic [3:0] seq_count
`ifdef RAND_NOTE_SCHED_REST_EN
  ,
  output logic       note_rest
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAW  = 3'd1,
    LATCH = 3'd2,
    OFFER = 3'd3,
    HOLD  = 3'd4,
    FIN   = 3'd5
  } state_t;

  localparam logic [4:0] SEQ_LEN_W = 5'(SEQ_LEN);

  state_t     state;
  state_t     state_next;
  logic [1:0] beat_cnt;
  logic       rest_q;
  logic       latch_rest;
  logic       hold_exit;
  logic [4:0] seq_count_inc;
  logic [3:0] mapped_note;

  // Pitch folding: values above the 12-key range wrap down by four keys.
  always_comb begin
    mapped_note = (rand_note < 4'd12) ? rand_note : (rand_note - 4'd4);
`ifdef RAND_NOTE_SCHED_REST_EN
    latch_rest  = (rand_note == 4'hF);
`else
    latch_rest  = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and Moore outputs; stop overrides every transition out of a busy state.
  always_comb begin
    state_next    = state;
    hold_exit     = 1'b0;
    seq_count_inc = {1'b0, seq_count} + 5'd1;
    unique case (state)
      IDLE:  if (start && !stop) state_next = DRAW;
      DRAW:  state_next = LATCH;
      LATCH: state_next = latch_rest ? HOLD : OFFER;
      OFFER: if (note_ready) state_next = HOLD;
      HOLD: begin
        if (beat_tick && (beat_cnt == 2'd0)) begin
          hold_exit  = 1'b1;
          state_next = (seq_count_inc == SEQ_LEN_W) ? FIN : DRAW;
        end
      end
      FIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (stop && (state != IDLE)) begin
      state_next = IDLE;
      hold_exit  = 1'b0;
    end

    enable_rand = (state == DRAW);
    note_valid  = (state == OFFER);
    note_on     = (state == HOLD) && !rest_q;
    busy        = (state != IDLE);
    done        = (state == FIN);
  end

`ifdef RAND_NOTE_SCHED_REST_EN
  // Rest gate mirrors note_on for a captured rest.
  always_comb begin
    note_rest = (state == HOLD) && rest_q;
  end
`endif

  // Datapath: captured note, beat countdown and sequence progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      note_idx  <= '0;
      beat_cnt  <= '0;
      seq_count <= '0;
      rest_q    <= 1'b0;
    end else begin
      if ((state == IDLE) && start && !stop) begin
        seq_count <= '0;
      end
      if ((state == LATCH) && !stop) begin
        note_idx <= mapped_note;
        beat_cnt <= rand_length;
        rest_q   <= latch_rest;
      end
      if ((state == HOLD) && beat_tick && !stop && (beat_cnt != 2'd0)) begin
        beat_cnt <= beat_cnt - 2'd1;
      end
      if (hold_exit) begin
        seq_count <= seq_count_inc[3:0];
      end
    end
  end

endmodule

// File: tb/tb_rand_note_sched.sv
// Bench for rand_note_sched: directed stimulus, per-cycle comparison against
// a note-level behavioural model, plus hand-computed literal checks.
module tb_rand_note_sched;

  localparam int unsigned SEQ = 2;
`ifdef RAND_NOTE_SCHED_REST_EN
  localparam bit REST = 1'b1;
`else
  localparam bit REST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       beat_tick = 1'b0;
  logic [3:0] rand_note = '0;
  logic [1:0] rand_length = '0;
  logic       note_ready = 1'b0;
  logic       enable_rand;
  logic       note_valid;
  logic [3:0] note_idx;
  logic       note_on;
  logic       busy;
  logic       done;
  logic [3:0] seq_count;
  logic       rest_out;

  rand_note_sched #(.SEQ_LEN(SEQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .beat_tick   (beat_tick),
    .rand_note   (rand_note),
    .rand_length (rand_length),
    .enable_rand (enable_rand),
    .note_valid  (note_valid),
    .note_ready  (note_ready),
    .note_idx    (note_idx),
    .note_on     (note_on),
    .busy        (busy),
    .done        (done),
    .seq_count   (seq_count)
`ifdef RAND_NOTE_SCHED_REST_EN
    ,
    .note_rest   (rest_out)
`endif
  );

`ifndef RAND_NOTE_SCHED_REST_EN
  assign rest_out = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Note-level model: phase 0 idle, 1 draw, 2 latch, 3 offer, 4 hold, 5 fin.
  // Hold length is tracked as beats still to be heard (1..4).
  int m_phase = 0;
  int m_idx = 0;
  int m_beats = 0;
  int m_seq = 0;
  bit m_rest = 0;
  bit m_live = 0;

  task automatic model_step();
    if (reset) begin
      m_phase = 0; m_idx = 0; m_beats = 0; m_seq = 0; m_rest = 0; m_live = 1;
    end else if (m_phase != 0 && stop) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (start && !stop) begin m_phase = 1; m_seq = 0; end
        1: m_phase = 2;
        2: begin
          m_idx   = (rand_note < 12) ? int'(rand_note) : int'(rand_note) - 4;
          m_beats = int'(rand_length) + 1;
          m_rest  = REST && (rand_note == 4'd15);
          m_phase = m_rest ? 4 : 3;
        end
        3: if (note_ready) m_phase = 4;
        4: if (beat_tick) begin
          m_beats = m_beats - 1;
          if (m_beats == 0) begin
            m_seq   = m_seq + 1;
            m_phase = (m_seq == SEQ) ? 5 : 1;
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("m_enable_rand", enable_rand, 8'(m_phase == 1));
      chk("m_note_valid",  note_valid,  8'(m_phase == 3));
      chk("m_note_on",     note_on,     8'(m_phase == 4 && !m_rest));
      chk("m_note_rest",   rest_out,    8'(m_phase == 4 && m_rest));
      chk("m_busy",        busy,        8'(m_phase != 0));
      chk("m_done",        done,        8'(m_phase == 5));
      chk("m_seq_count",   seq_count,   8'(m_seq));
      chk("m_note_idx",    note_idx,    8'(m_idx));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat();
    beat_tick = 1'b1;
    tick();
    beat_tick = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_enable_rand"}, enable_rand, 8'd0);
    chk({tag, "_note_valid"},  note_valid,  8'd0);
    chk({tag, "_note_idx"},    note_idx,    8'd0);
    chk({tag, "_note_on"},     note_on,     8'd0);
    chk({tag, "_note_rest"},   rest_out,    8'd0);
    chk({tag, "_busy"},        busy,        8'd0);
    chk({tag, "_done"},        done,        8'd0);
    chk({tag, "_seq_count"},   seq_count,   8'd0);
  endtask

  initial begin
    tick(); tick();
    chk_reset_vals("rst");
    reset = 1'b0;

    // Basic note: pitch 5, three beats, player always ready.
    rand_note = 4'd5; rand_length = 2'd2; note_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat_enable_c1", enable_rand, 8'd1);
    chk("lat_valid_c1", note_valid, 8'd0);
    tick();
    chk("lat_enable_c2", enable_rand, 8'd0);
    tick();
    chk("lat_valid_c3", note_valid, 8'd1);
    chk("lat_idx_c3", note_idx, 8'd5);
    tick();
    for (int b = 0; b < 3; b++) begin
      chk("hold3_on", note_on, 8'd1);
      tick();
      chk("hold3_on_gap", note_on, 8'd1);
      beat();
    end
    chk("hold3_off", note_on, 8'd0);
    chk("seq_after_1", seq_count, 8'd1);
    chk("busy_after_1", busy, 8'd1);

    // Second note of the sequence: one beat, then completion.
    rand_length = 2'd0;
    tick(); tick();
    chk("n2_valid", note_valid, 8'd1);
    tick();
    chk("n2_on", note_on, 8'd1);
    beat();
    chk("fin_done", done, 8'd1);
    chk("fin_seq", seq_count, 8'd2);
    tick();
    chk("fin_done_once", done, 8'd0);
    chk("fin_busy", busy, 8'd0);
    chk("fin_seq_held", seq_count, 8'd2);

    // Stalled offer with pitch 14; beats during the stall must not count.
    rand_note = 4'd14; rand_length = 2'd1; note_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_seq_clr", seq_count, 8'd0);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      beat_tick = (i % 2 == 0);
      chk("stall_valid", note_valid, 8'd1);
      chk("stall_idx", note_idx, 8'd10);
      tick();
    end
    beat_tick = 1'b0;
    chk("stall_valid_end", note_valid, 8'd1);
    note_ready = 1'b1;
    tick();
    chk("stall_hold", note_on, 8'd1);
    beat();
    chk("stall_hold_1beat", note_on, 8'd1);
    beat();
    chk("stall_hold_done", note_on, 8'd0);
    chk("stall_seq", seq_count, 8'd1);

    // Abort during the second hold.
    rand_note = 4'd3;
    tick(); tick(); tick();
    chk("abort_on", note_on, 8'd1);
    chk("abort_idx", note_idx, 8'd3);
    stop = 1'b1;
    tick();
    chk("abort_busy", busy, 8'd0);
    chk("abort_on_off", note_on, 8'd0);
    chk("abort_done", done, 8'd0);
    chk("abort_seq", seq_count, 8'd1);
    start = 1'b1;
    tick();
    chk("startstop_busy", busy, 8'd0);
    chk("startstop_en", enable_rand, 8'd0);
    tick();
    chk("startstop_busy2", busy, 8'd0);
    start = 1'b0; stop = 1'b0;

    // Pitch 15: rest when the feature is built in, key 11 otherwise.
    rand_note = 4'd15; rand_length = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
`ifdef RAND_NOTE_SCHED_REST_EN
    chk("rest_valid", note_valid, 8'd0);
    chk("rest_flag", rest_out, 8'd1);
    chk("rest_on", note_on, 8'd0);
    beat();
    chk("rest_flag_b1", rest_out, 8'd1);
    beat();
    chk("rest_flag_end", rest_out, 8'd0);
    chk("rest_seq", seq_count, 8'd1);
`else
    chk("p15_valid", note_valid, 8'd1);
    chk("p15_idx", note_idx, 8'd11);
`endif
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("p15_stop_busy", busy, 8'd0);

    // Reset while offering.
    rand_note = 4'd7; note_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("rstoffer_valid", note_valid, 8'd1);
    chk("rstoffer_idx", note_idx, 8'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("rstoffer");
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
